// File: rtl/jtag_shift_ctrl.sv
// jtag_shift_ctrl: sequencing controller for the ARM JTAG level-shifting buffer.
//
// Takes byte-wide commands from the USB-side decoder and drives the buffer's
// 3.3V-side controls. SHIFT clocks out up to NBITS TMS/TDI bits, LSB first,
// with a TCK half-period of CLK_DIV+1 cycles, and captures TDO on each TCK rise.
// SET_PINS and SET_OE update the reset-line and JTAG output enables.
//
// Ports:
//   CLK, RST                  system clock, synchronous active-high reset
//   CMD_VALID/READY/OP/LEN/READ/TDI/TMS  command handshake and payload
//   CLK_DIV                   TCK half-period minus 1, latched at SHIFT accept
//   RSP_VALID/READY/TDO       response handshake with captured TDO bits
//   TDO_IN, VREF_N_IN         inputs from the buffer (VREF_N_IN is asynchronous)
//   JTAG_OE_N, TCK_OUT, TMS_OUT, TDI_OUT       JTAG drive to the buffer
//   TRST_N_OE_N/OUT, SRST_N_OE_N/OUT           open-drain style reset lines
//   BUSY                      controller not idle
//   FAULT                     one-cycle pulse: SHIFT refused, target VREF absent
module jtag_shift_ctrl #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned NBITS = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [2:0]       CMD_LEN,
  input  logic             CMD_READ,
  input  logic [NBITS-1:0] CMD_TDI,
  input  logic [NBITS-1:0] CMD_TMS,
  input  logic [DIV_W-1:0] CLK_DIV,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [NBITS-1:0] RSP_TDO,
  input  logic             TDO_IN,
  input  logic             VREF_N_IN,
  output logic             JTAG_OE_N,
  output logic             TCK_OUT,
  output logic             TMS_OUT,
  output logic             TDI_OUT,
  output logic             TRST_N_OE_N,
  output logic             TRST_N_OUT,
  output logic             SRST_N_OE_N,
  output logic             SRST_N_OUT,
  output logic             BUSY,
  output logic             FAULT
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLow  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [1:0] OpShift   = 2'd0;
  localparam logic [1:0] OpSetPins = 2'd1;
  localparam logic [1:0] OpSetOe   = 2'd2;
  localparam logic [1:0] OpNop     = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             vref_meta_q, vref_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       len_q, len_d;
  logic             read_q, read_d;
  logic [NBITS-1:0] sh_tdi_q, sh_tdi_d;
  logic [NBITS-1:0] sh_tms_q, sh_tms_d;
  logic             tms_out_q, tms_out_d;
  logic             tdi_out_q, tdi_out_d;
  logic             jtag_oe_n_q, jtag_oe_n_d;
  logic             trst_oe_n_q, trst_oe_n_d;
  logic             srst_oe_n_q, srst_oe_n_d;
  logic             fault_q, fault_d;
  logic [NBITS-1:0] rsp_tdo_q, rsp_tdo_d;

  logic       accept;
  logic       phase_done;
  logic [2:0] idx_nxt;

  assign accept     = CMD_VALID && ready_q;
  // Counter runs 0..div inclusive, so an all-ones divider gives 2^DIV_W cycles.
  assign phase_done = (cnt_q == div_q);
  assign idx_nxt    = idx_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    len_d       = len_q;
    read_d      = read_q;
    sh_tdi_d    = sh_tdi_q;
    sh_tms_d    = sh_tms_q;
    tms_out_d   = tms_out_q;
    tdi_out_d   = tdi_out_q;
    jtag_oe_n_d = jtag_oe_n_q;
    trst_oe_n_d = trst_oe_n_q;
    srst_oe_n_d = srst_oe_n_q;
    rsp_tdo_d   = rsp_tdo_q;
    fault_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (CMD_OP)
            OpSetPins: begin
              trst_oe_n_d = ~CMD_TDI[0];
              srst_oe_n_d = ~CMD_TDI[1];
            end
            OpSetOe: jtag_oe_n_d = ~CMD_TDI[0];
            OpShift: begin
              if (vref_sync_q) begin
                // No target power: refuse without toggling TCK.
                fault_d = 1'b1;
                if (CMD_READ) begin
                  rsp_tdo_d = '1;
                  state_d   = StResp;
                end
              end else begin
                div_d     = CLK_DIV;
                cnt_d     = '0;
                idx_d     = 3'd0;
                len_d     = CMD_LEN;
                read_d    = CMD_READ;
                sh_tdi_d  = CMD_TDI;
                sh_tms_d  = CMD_TMS;
                tms_out_d = CMD_TMS[0];
                tdi_out_d = CMD_TDI[0];
                rsp_tdo_d = '0;
                state_d   = StLow;
              end
            end
            OpNop: ;
            default: ;
          endcase
        end
      end
      StLow: begin
        if (phase_done) begin
          cnt_d            = '0;
          // TDO is sampled on the same edge that raises TCK.
          rsp_tdo_d[idx_q] = TDO_IN;
          state_d          = StHigh;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StHigh: begin
        if (phase_done) begin
          cnt_d = '0;
          if (idx_q < len_q) begin
            idx_d     = idx_nxt;
            tms_out_d = sh_tms_q[idx_nxt];
            tdi_out_d = sh_tdi_q[idx_nxt];
            state_d   = StLow;
          end else begin
            state_d = read_q ? StResp : StIdle;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StResp: begin
        if (RSP_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      vref_meta_q <= 1'b1;
      vref_sync_q <= 1'b1;
      div_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      len_q       <= 3'd0;
      read_q      <= 1'b0;
      sh_tdi_q    <= '0;
      sh_tms_q    <= '0;
      tms_out_q   <= 1'b1;
      tdi_out_q   <= 1'b1;
      jtag_oe_n_q <= 1'b1;
      trst_oe_n_q <= 1'b1;
      srst_oe_n_q <= 1'b1;
      fault_q     <= 1'b0;
      rsp_tdo_q   <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      vref_meta_q <= VREF_N_IN;
      vref_sync_q <= vref_meta_q;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      read_q      <= read_d;
      sh_tdi_q    <= sh_tdi_d;
      sh_tms_q    <= sh_tms_d;
      tms_out_q   <= tms_out_d;
      tdi_out_q   <= tdi_out_d;
      jtag_oe_n_q <= jtag_oe_n_d;
      trst_oe_n_q <= trst_oe_n_d;
      srst_oe_n_q <= srst_oe_n_d;
      fault_q     <= fault_d;
      rsp_tdo_q   <= rsp_tdo_d;
    end
  end

  assign CMD_READY   = ready_q;
  assign RSP_VALID   = (state_q == StResp);
  assign RSP_TDO     = rsp_tdo_q;
  assign TCK_OUT     = (state_q == StHigh);
  assign TMS_OUT     = tms_out_q;
  assign TDI_OUT     = tdi_out_q;
  assign JTAG_OE_N   = jtag_oe_n_q;
  assign TRST_N_OE_N = trst_oe_n_q;
  assign SRST_N_OE_N = srst_oe_n_q;
  // Reset lines are open-drain: only the enables toggle.
  assign TRST_N_OUT  = 1'b0;
  assign SRST_N_OUT  = 1'b0;
  assign BUSY        = (state_q != StIdle);
  assign FAULT       = fault_q;

endmodule

// File: tb/tb_jtag_shift_ctrl.sv
module tb_jtag_shift_ctrl;

  localparam int DIV_W = 8;
  localparam int NBITS = 8;

  localparam logic [1:0] OP_SHIFT = 2'd0;
  localparam logic [1:0] OP_PINS  = 2'd1;
  localparam logic [1:0] OP_OE    = 2'd2;

  logic             CLK = 1'b0;
  logic             RST;
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic [2:0]       CMD_LEN;
  logic             CMD_READ;
  logic [NBITS-1:0] CMD_TDI;
  logic [NBITS-1:0] CMD_TMS;
  logic [DIV_W-1:0] CLK_DIV;
  logic             RSP_VALID;
  logic             RSP_READY;
  logic [NBITS-1:0] RSP_TDO;
  logic             TDO_IN;
  logic             VREF_N_IN;
  logic             JTAG_OE_N, TCK_OUT, TMS_OUT, TDI_OUT;
  logic             TRST_N_OE_N, TRST_N_OUT, SRST_N_OE_N, SRST_N_OUT;
  logic             BUSY, FAULT;

  logic loopback;
  logic tdo_drv;
  assign TDO_IN = loopback ? TDI_OUT : tdo_drv;

  always #5 CLK = ~CLK;

  jtag_shift_ctrl #(.DIV_W(DIV_W), .NBITS(NBITS)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_LEN(CMD_LEN),
    .CMD_READ(CMD_READ), .CMD_TDI(CMD_TDI), .CMD_TMS(CMD_TMS), .CLK_DIV(CLK_DIV),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_TDO(RSP_TDO),
    .TDO_IN(TDO_IN), .VREF_N_IN(VREF_N_IN),
    .JTAG_OE_N(JTAG_OE_N), .TCK_OUT(TCK_OUT), .TMS_OUT(TMS_OUT), .TDI_OUT(TDI_OUT),
    .TRST_N_OE_N(TRST_N_OE_N), .TRST_N_OUT(TRST_N_OUT),
    .SRST_N_OE_N(SRST_N_OE_N), .SRST_N_OUT(SRST_N_OUT),
    .BUSY(BUSY), .FAULT(FAULT)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one command; returns at T+1 (just after the accepting edge).
  task automatic send(input logic [1:0] op, input logic [2:0] len, input logic rd,
                      input logic [7:0] tdi, input logic [7:0] tms);
    check("ready_before_cmd", CMD_READY, 1);
    CMD_OP    = op;
    CMD_LEN   = len;
    CMD_READ  = rd;
    CMD_TDI   = tdi;
    CMD_TMS   = tms;
    CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
  endtask

  // Observe a running shift from T+1 (k=1) until RSP_VALID or idle.
  task automatic watch(input bit want_rsp, output int first_rise, output int last_rise,
                       output int n_rise, output int hi_cycles, output int end_k,
                       output logic [7:0] tms_seen, output logic [7:0] tdi_seen);
    int   k;
    logic prev;
    k = 1; prev = 1'b0;
    first_rise = -1; last_rise = -1; n_rise = 0; hi_cycles = 0;
    tms_seen = '0; tdi_seen = '0;
    while (k < 3000) begin
      if (want_rsp ? RSP_VALID : !BUSY) break;
      if (TCK_OUT) begin
        hi_cycles++;
        if (!prev) begin
          if (n_rise == 0) first_rise = k;
          last_rise = k;
          if (n_rise < 8) begin
            tms_seen[n_rise[2:0]] = TMS_OUT;
            tdi_seen[n_rise[2:0]] = TDI_OUT;
          end
          n_rise++;
        end
      end
      prev = TCK_OUT;
      tick();
      k++;
    end
    end_k = k;
    check("watch_in_budget", (k < 3000), 1);
  endtask

  int         fr, lr, nr, hc, ek;
  logic [7:0] tms_s, tdi_s;

  initial begin
    RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_LEN = '0; CMD_READ = 1'b0;
    CMD_TDI = '0; CMD_TMS = '0; CLK_DIV = '0; RSP_READY = 1'b0;
    VREF_N_IN = 1'b0; loopback = 1'b0; tdo_drv = 1'b0;
    tick(); tick();

    // Reset values
    check("rst_cmd_ready", CMD_READY, 0);
    check("rst_rsp_valid", RSP_VALID, 0);
    check("rst_rsp_tdo", RSP_TDO, 0);
    check("rst_tck", TCK_OUT, 0);
    check("rst_tms", TMS_OUT, 1);
    check("rst_tdi", TDI_OUT, 1);
    check("rst_oe_n", JTAG_OE_N, 1);
    check("rst_trst_oe_n", TRST_N_OE_N, 1);
    check("rst_srst_oe_n", SRST_N_OE_N, 1);
    check("rst_trst_out", TRST_N_OUT, 0);
    check("rst_srst_out", SRST_N_OUT, 0);
    check("rst_busy", BUSY, 0);
    check("rst_fault", FAULT, 0);

    RST = 1'b0;
    tick();
    check("ready_after_rst", CMD_READY, 1);
    tick(); tick();

    // Pin control
    send(OP_OE, 3'd0, 1'b0, 8'h01, 8'h00);
    check("set_oe_oe_n", JTAG_OE_N, 0);
    check("set_oe_no_rsp", RSP_VALID, 0);
    send(OP_PINS, 3'd0, 1'b0, 8'h02, 8'h00);
    check("set_pins_srst", SRST_N_OE_N, 0);
    check("set_pins_trst", TRST_N_OE_N, 1);
    check("set_pins_no_rsp", RSP_VALID, 0);
    check("set_pins_busy", BUSY, 0);

    // 8-bit loopback shift, CLK_DIV=0
    loopback = 1'b1;
    CLK_DIV  = 8'd0;
    send(OP_SHIFT, 3'd7, 1'b1, 8'hA5, 8'h80);
    check("lb_busy", BUSY, 1);
    check("lb_ready_low", CMD_READY, 0);
    watch(1'b1, fr, lr, nr, hc, ek, tms_s, tdi_s);
    check("lb_n_rise", nr, 8);
    check("lb_first_rise", fr, 2);
    check("lb_last_rise", lr, 16);
    check("lb_hi_cycles", hc, 8);
    check("lb_rsp_at", ek, 17);
    check("lb_tms_bits", tms_s, 8'h80);
    check("lb_tdi_bits", tdi_s, 8'hA5);
    check("lb_rsp_tdo", RSP_TDO, 8'hA5);
    check("lb_tms_hold", TMS_OUT, 1);
    check("lb_tdi_hold", TDI_OUT, 1);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    check("lb_rsp_done", RSP_VALID, 0);
    check("lb_idle", BUSY, 0);
    check("lb_ready_again", CMD_READY, 1);
    loopback = 1'b0;

    // 3-bit shift, CLK_DIV=3, divider changed mid-command
    tdo_drv = 1'b1;
    CLK_DIV = 8'd3;
    send(OP_SHIFT, 3'd2, 1'b1, 8'h00, 8'h00);
    CLK_DIV = 8'd0;
    watch(1'b1, fr, lr, nr, hc, ek, tms_s, tdi_s);
    check("d3_n_rise", nr, 3);
    check("d3_first_rise", fr, 5);
    check("d3_last_rise", lr, 21);
    check("d3_hi_cycles", hc, 12);
    check("d3_rsp_at", ek, 25);
    check("d3_rsp_tdo", RSP_TDO, 8'h07);

    // Back-pressure on the response
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", RSP_VALID, 1);
      check("bp_rsp_tdo", RSP_TDO, 8'h07);
      check("bp_cmd_ready", CMD_READY, 0);
      tick();
    end
    RSP_READY = 1'b1;
    tick();
    check("bp_released", RSP_VALID, 0);
    check("bp_idle", BUSY, 0);
    tick();
    check("bp_single_xfer", RSP_VALID, 0);
    RSP_READY = 1'b0;
    tdo_drv = 1'b0;

    // Maximum divider, single bit, no read
    CLK_DIV = 8'hFF;
    send(OP_SHIFT, 3'd0, 1'b0, 8'h01, 8'h01);
    watch(1'b0, fr, lr, nr, hc, ek, tms_s, tdi_s);
    check("dmax_n_rise", nr, 1);
    check("dmax_first_rise", fr, 257);
    check("dmax_hi_cycles", hc, 256);
    check("dmax_idle_at", ek, 513);
    check("dmax_no_rsp", RSP_VALID, 0);
    CLK_DIV = 8'd0;

    // VREF absent -> fault
    VREF_N_IN = 1'b1;
    tick(); tick(); tick();
    send(OP_SHIFT, 3'd7, 1'b1, 8'h00, 8'h00);
    check("vref_fault", FAULT, 1);
    check("vref_tck", TCK_OUT, 0);
    check("vref_rsp_valid", RSP_VALID, 1);
    check("vref_rsp_tdo", RSP_TDO, 8'hFF);
    tick();
    check("vref_fault_pulse", FAULT, 0);
    check("vref_tck_still", TCK_OUT, 0);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    check("vref_rsp_done", RSP_VALID, 0);
    VREF_N_IN = 1'b0;
    tick(); tick(); tick();

    // Reset during bit 3 of an 8-bit shift (SRST still asserted)
    CLK_DIV = 8'd1;
    send(OP_SHIFT, 3'd7, 1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 14; i++) tick();
    check("mid_tck_high", TCK_OUT, 1);
    check("mid_tms_low", TMS_OUT, 0);
    check("mid_srst_asserted", SRST_N_OE_N, 0);
    RST = 1'b1;
    tick();
    check("mr_tck", TCK_OUT, 0);
    check("mr_tms", TMS_OUT, 1);
    check("mr_tdi", TDI_OUT, 1);
    check("mr_srst_oe_n", SRST_N_OE_N, 1);
    check("mr_oe_n", JTAG_OE_N, 1);
    check("mr_busy", BUSY, 0);
    check("mr_rsp_valid", RSP_VALID, 0);
    check("mr_rsp_tdo", RSP_TDO, 0);
    check("mr_cmd_ready", CMD_READY, 0);
    RST = 1'b0;
    tick();
    check("mr_ready_after", CMD_READY, 1);
    check("mr_no_rsp", RSP_VALID, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
